// File: rtl/pc_step_ctrl.sv
// Program-counter owner for the debug front panel: single-step and clear over
// four-phase handshakes, divided free-run mode, and breakpoint halt.
module pc_step_ctrl #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned RUN_DIV  = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic            clk,
  input  logic            resetpin,
  input  logic            step_req,
  output logic            step_ack,
  input  logic            clr_req,
  output logic            clr_ack,
  input  logic            run,
  input  logic            brk_en,
  input  logic [PC_W-1:0] brk_addr,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic [CNT_W-1:0] step_cnt
);

  localparam int unsigned PRE_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_BRK  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic             step_ack_q, step_ack_d;
  logic             clr_ack_q, clr_ack_d;
  logic             halted_q, halted_d;

  logic             clr_acc_c;
  logic             step_ok_c;
  logic             step_acc_c;
  logic             advance_c;
  logic             presc_tc_c;
  logic [PC_W-1:0]  pc_inc_c;

  always_ff @(posedge clk or negedge resetpin) begin
    if (!resetpin) begin
      state_q    <= ST_IDLE;
      pc_q       <= PC_W'(RESET_PC);
      cnt_q      <= '0;
      presc_q    <= '0;
      step_ack_q <= 1'b0;
      clr_ack_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      presc_q    <= presc_d;
      step_ack_q <= step_ack_d;
      clr_ack_q  <= clr_ack_d;
      halted_q   <= halted_d;
    end
  end

  // Steps are taken in IDLE (when not starting a run) and in BRK; clear always wins.
  always_comb begin
    pc_inc_c   = pc_q + PC_W'(1);
    presc_tc_c = (presc_q == PRE_W'(RUN_DIV - 1));
    clr_acc_c  = clr_req && !clr_ack_q;
    step_ok_c  = ((state_q == ST_IDLE) && !run) || (state_q == ST_BRK);
    step_acc_c = step_req && !step_ack_q && step_ok_c && !clr_acc_c;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    presc_d    = presc_q;
    halted_d   = halted_q;
    advance_c  = 1'b0;
    step_ack_d = step_ack_q;
    clr_ack_d  = clr_ack_q;

    if (!step_req) step_ack_d = 1'b0;
    else if (step_acc_c) step_ack_d = 1'b1;
    if (!clr_req) clr_ack_d = 1'b0;
    else if (clr_acc_c) clr_ack_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_RUN;
          presc_d = '0;
        end else if (step_acc_c) begin
          advance_c = 1'b1;
        end
      end
      ST_RUN: begin
        if (!run) begin
          state_d = ST_IDLE;
          presc_d = '0;
        end else if (presc_tc_c) begin
          presc_d = '0;
          if (!clr_acc_c) begin
            advance_c = 1'b1;
            if (brk_en && (pc_inc_c == brk_addr)) begin
              state_d  = ST_BRK;
              halted_d = 1'b1;
            end
          end
        end else begin
          presc_d = presc_q + PRE_W'(1);
        end
      end
      ST_BRK: begin
        if (!run) begin
          state_d  = ST_IDLE;
          halted_d = 1'b0;
        end
        if (step_acc_c) advance_c = 1'b1;
      end
      default: begin
        state_d  = ST_IDLE;
        halted_d = 1'b0;
      end
    endcase

    if (advance_c) pc_d = pc_inc_c;
    if (clr_acc_c) begin
      pc_d    = PC_W'(RESET_PC);
      presc_d = '0;
    end
  end

  // Saturating count of PC advances; clears do not touch it.
  always_comb begin
    cnt_d = cnt_q;
    if (advance_c && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  assign pc       = pc_q;
  assign step_ack = step_ack_q;
  assign clr_ack  = clr_ack_q;
  assign halted   = halted_q;
  assign step_cnt = cnt_q;

endmodule
